// File: rtl/perf_pkg.sv
// Shared types and constants for the performance event monitor.
package perf_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } perf_state_e;

    localparam int CH_CYCLE  = 0;
    localparam int EVT_STALL = 0;
    localparam int EVT_FLUSH = 1;

    // Index width for n channels, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One monitor channel: clearable counter with sticky overflow.
// Wraps to zero on overflow, or sticks at all-ones when PERF_SATURATE_EN is defined.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_reg;
    logic             ovf_next;

    always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (clr_i) begin
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (inc_i) begin
            if (&cnt_reg) begin
                ovf_next = 1'b1;
`ifdef PERF_SATURATE_EN
                cnt_next = cnt_reg;
`else
                cnt_next = '0;
`endif
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

    assign cnt_o      = cnt_reg;
    assign cnt_next_o = cnt_next;
    assign ovf_o      = ovf_reg;

endmodule

// File: rtl/perf_event_monitor.sv
// Cycle/event counter bank with cycle-limit halt and valid/ready snapshot dump.
// Overflow behaviour selected by PERF_SATURATE_EN (saturate) vs. default (wrap).
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVT = 2,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = idx_width(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic [CNT_W-1:0]   limit_i,
    output logic               halt_o,
    output logic [NUM_EVT:0]   ovf_o,
    input  logic               snap_i,
    output logic               busy_o,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [IDX_W-1:0]   rd_idx_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_last_o
);

    localparam int         NUM_CH   = NUM_EVT + 1;
    localparam [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    logic [CNT_W-1:0]  live_cnt  [NUM_CH];
    logic [CNT_W-1:0]  live_next [NUM_CH];
    logic [CNT_W-1:0]  shadow_reg[NUM_CH];
    logic [NUM_CH-1:0] ch_inc;
    logic [NUM_CH-1:0] ovf_w;

    logic        en;
    logic        halt_reg;
    logic        halt_next;
    logic        snap_take;
    perf_state_e state_reg;
    perf_state_e state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;

    assign en               = start_i & ~halt_reg;
    assign ch_inc[CH_CYCLE] = en;

    generate
        for (genvar gi = 1; gi < NUM_CH; gi++) begin : g_evt_inc
            assign ch_inc[gi] = en & event_i[gi-1];
        end

        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            perf_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .clr_i      (clear_i),
                .inc_i      (ch_inc[gi]),
                .cnt_o      (live_cnt[gi]),
                .cnt_next_o (live_next[gi]),
                .ovf_o      (ovf_w[gi])
            );

            // Shadows only load on an accepted snapshot; clear_i leaves them alone.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    shadow_reg[gi] <= '0;
                end else if (snap_take) begin
                    shadow_reg[gi] <= live_cnt[gi];
                end
            end
        end
    endgenerate

    // Equality-only compare, evaluated only on edges where the cycle counter advances.
    always_comb begin
        halt_next = halt_reg;
        if (clear_i) begin
            halt_next = 1'b0;
        end else if (en && (limit_i != '0) && (live_next[CH_CYCLE] == limit_i)) begin
            halt_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halt_reg <= 1'b0;
        end else begin
            halt_reg <= halt_next;
        end
    end

    assign snap_take = (state_reg == ST_IDLE) && snap_i;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (snap_i) begin
                    state_next = ST_DUMP;
                    idx_next   = '0;
                end
            end
            ST_DUMP: begin
                if (rd_ready_i) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    assign busy_o     = (state_reg == ST_DUMP);
    assign rd_valid_o = busy_o;
    assign rd_idx_o   = idx_reg;
    assign rd_last_o  = busy_o && (idx_reg == LAST_IDX);
    assign rd_data_o  = busy_o ? shadow_reg[idx_reg] : '0;
    assign halt_o     = halt_reg;
    assign ovf_o      = ovf_w;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed self-checking bench: a 32-bit monitor plus a 4-bit one for overflow.
module tb_perf_event_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_start;
    logic        clear;
    logic [1:0]  evt;
    logic [31:0] limit;
    logic        snap;
    logic        ready;

    logic        halt,  s_halt;
    logic [2:0]  ovf,   s_ovf;
    logic        busy,  s_busy;
    logic        valid, s_valid;
    logic [1:0]  idx,   s_idx;
    logic [31:0] rdata;
    logic [3:0]  s_rdata;
    logic        last,  s_last;

    int checks = 0;
    int fails  = 0;
    logic [31:0] snap_vals [3];
    logic [3:0]  s_beat0;

    always #5 clk = ~clk;

    perf_event_monitor #(.NUM_EVT(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(evt), .limit_i(limit), .halt_o(halt), .ovf_o(ovf),
        .snap_i(snap), .busy_o(busy), .rd_valid_o(valid), .rd_ready_i(ready),
        .rd_idx_o(idx), .rd_data_o(rdata), .rd_last_o(last)
    );

    perf_event_monitor #(.NUM_EVT(2), .CNT_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(clear),
        .event_i(evt), .limit_i(limit[3:0]), .halt_o(s_halt), .ovf_o(s_ovf),
        .snap_i(snap), .busy_o(s_busy), .rd_valid_o(s_valid), .rd_ready_i(ready),
        .rd_idx_o(s_idx), .rd_data_o(s_rdata), .rd_last_o(s_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Snapshot the live counters and collect all three beats with ready held high.
    task automatic dump();
        snap = 1'b1;
        tick();
        snap  = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            int n;
            n = 0;
            while (!valid && n < 4) begin
                tick();
                n++;
            end
            check("dump_valid", 32'(valid), 32'd1);
            check("dump_idx", 32'(idx), 32'(c));
            check("dump_last", 32'(last), 32'(c == 2));
            snap_vals[c] = rdata;
            if (c == 0) s_beat0 = s_rdata;
            tick();
        end
        check("dump_busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_small;
        rst = 1'b1; start = 1'b0; s_start = 1'b0; clear = 1'b0;
        evt = 2'b00; limit = 32'd0; snap = 1'b0; ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_s_ovf", 32'(s_ovf), 32'd0);

        // 4-bit channel driven through 17 enabled cycles
        s_start = 1'b1;
        repeat (17) tick();
        s_start = 1'b0;
        check("small_ovf", 32'(s_ovf), 32'd1);
`ifdef PERF_SATURATE_EN
        exp_small = 32'd15;
`else
        exp_small = 32'd1;
`endif
        dump();
        check("small_ch0", 32'(s_beat0), exp_small);
        check("idle_ch0", snap_vals[0], 32'd0);

        // Ten counting cycles with stall strobes on cycles 3 and 4
        start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            evt = (i == 3 || i == 4) ? 2'b01 : 2'b00;
            tick();
        end
        start = 1'b0;
        evt   = 2'b00;
        dump();
        check("basic_ch0", snap_vals[0], 32'd10);
        check("basic_ch1", snap_vals[1], 32'd2);
        check("basic_ch2", snap_vals[2], 32'd0);

        // Halt at a cycle limit of 30
        clear = 1'b1;
        tick();
        clear = 1'b0;
        limit = 32'd30;
        start = 1'b1;
        for (int i = 1; i <= 29; i++) tick();
        check("halt_before", 32'(halt), 32'd0);
        tick();
        check("halt_at_limit", 32'(halt), 32'd1);
        evt = 2'b01;
        repeat (3) tick();
        start = 1'b0;
        evt   = 2'b00;
        check("halt_sticky", 32'(halt), 32'd1);
        dump();
        check("halt_ch0", snap_vals[0], 32'd30);
        check("halt_ch1_frozen", snap_vals[1], 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_halt", 32'(halt), 32'd0);
        start = 1'b1;
        repeat (5) tick();
        limit = 32'd3;
        repeat (2) tick();
        check("limit_below_no_halt", 32'(halt), 32'd0);
        start = 1'b0;
        limit = 32'd0;
        dump();
        check("resume_ch0", snap_vals[0], 32'd7);

        // Snapshot with ready pattern 1,0,1,1 while counting continues
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        evt   = 2'b10;
        repeat (7) tick();
        evt   = 2'b01;
        snap  = 1'b1;
        ready = 1'b1;
        tick();
        snap = 1'b0;
        check("hs_busy", 32'(busy), 32'd1);
        check("hs_idx0", 32'(idx), 32'd0);
        check("hs_data0", rdata, 32'd7);
        check("hs_last0", 32'(last), 32'd0);
        tick();
        ready = 1'b0;
        snap  = 1'b1;
        check("hs_idx1", 32'(idx), 32'd1);
        check("hs_data1", rdata, 32'd0);
        tick();
        check("hs_stall_valid", 32'(valid), 32'd1);
        check("hs_stall_idx", 32'(idx), 32'd1);
        check("hs_stall_data", rdata, 32'd0);
        ready = 1'b1;
        snap  = 1'b0;
        tick();
        check("hs_idx2", 32'(idx), 32'd2);
        check("hs_data2", rdata, 32'd7);
        check("hs_last2", 32'(last), 32'd1);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        check("hs_busy_fall", 32'(busy), 32'd0);
        check("hs_valid_fall", 32'(valid), 32'd0);
        tick();
        check("snap_in_dump_ignored", 32'(busy), 32'd0);
        start = 1'b0;
        evt   = 2'b00;

        // clear_i wins over a same-cycle flush strobe
        start = 1'b1;
        evt   = 2'b10;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        evt   = 2'b00;
        dump();
        check("clr_ch0", snap_vals[0], 32'd0);
        check("clr_ch2", snap_vals[2], 32'd0);

        // Reset in the middle of a dump
        start = 1'b1;
        evt   = 2'b11;
        repeat (4) tick();
        start = 1'b0;
        evt   = 2'b00;
        snap  = 1'b1;
        tick();
        snap  = 1'b0;
        ready = 1'b1;
        tick();
        check("mid_idx1", 32'(idx), 32'd1);
        check("mid_data1", rdata, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_s_ovf", 32'(s_ovf), 32'd0);
        dump();
        check("rst_mid_ch0", snap_vals[0], 32'd0);
        check("rst_mid_ch1", snap_vals[1], 32'd0);
        check("rst_mid_ch2", snap_vals[2], 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/perf_event_monitor.md
# perf_event_monitor

Parametrised, synthesisable cycle/event counter bank that sits beside the pipelined CPU and replaces bench-side stall/flush/cycle bookkeeping. It counts cycles and NUM_EVT pipeline event pulses (stall, flush, …), raises a halt flag at a programmable cycle limit, and streams a coherent snapshot of all counters over a valid/ready port. The CPU top instantiates it and wires hazard-unit strobes to `event_i`.

## Interface
- NUM_EVT, 2: number of event channels; total channels NUM_CH = NUM_EVT+1 (channel 0 = cycles)
- CNT_W, 32: counter width, ≥ 2
- IDX_W, $clog2(NUM_CH) (min 1): channel index width, derived
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  counting enable
- clear_i  in  1  synchronous clear of live counters, overflow flags, and halt
- event_i  in  NUM_EVT  per-cycle event strobes; bit k feeds channel k+1
- limit_i  in  CNT_W  cycle limit; 0 = unlimited
- halt_o  out  1  cycle counter reached limit (sticky)
- ovf_o  out  NUM_CH  per-channel sticky overflow
- snap_i  in  1  snapshot request
- busy_o  out  1  dump in progress
- rd_valid_o  out  1  snapshot beat valid
- rd_ready_i  in  1  consumer accepts beat
- rd_idx_o  out  IDX_W  channel index of beat
- rd_data_o  out  CNT_W  counter value of beat
- rd_last_o  out  1  beat is channel NUM_CH-1

## Operation
- Reset: all counters, shadows, ovf_o, halt_o, rd_* and busy_o = 0; state IDLE.
- Count enable `en = start_i & ~halt_o`. Channel 0 increments each enabled cycle; channel k increments when `en & event_i[k-1]`.
- Priority: rst_i > clear_i > increment. clear_i never touches shadows or dump state.
- Overflow: increment at all-ones sets ovf_o[ch]; value behaviour per Configuration.
- Halt: when `limit_i != 0` and channel 0's next value equals limit_i, halt_o is set at that edge and stays set until clear_i/rst_i. Counting freezes while halted. Changing limit_i below the current count does not halt (equality only).
- FSM IDLE→DUMP: snap_i in IDLE copies every live counter's current (pre-increment) value into shadows, idx=0. Events in the snap cycle appear in live counters, not the snapshot.
- DUMP: rd_valid_o=1, rd_data_o=shadow[idx]. On valid&ready: if idx==NUM_CH-1, go IDLE, else idx+1. Beat is held stable while ready is low. snap_i in DUMP (including the final-beat cycle) is ignored.
- busy_o = (state==DUMP). Counting continues during DUMP.

## Timing
- Live counter reflects an event one edge after the strobe.
- halt_o is registered and asserted in the cycle after the limit-reaching edge; channel 0 then reads exactly limit_i.
- rd_valid_o rises one cycle after an accepted snap_i. With ready held high, a full dump takes NUM_CH consecutive cycles at one beat per cycle. rd_valid_o drops the cycle after the last handshake.
- Earliest next snap_i acceptance: the first IDLE cycle after the dump.
- rst_i mid-dump aborts to IDLE next edge, and rd_valid_o = 0.

## Configuration
- PERF_SATURATE_EN defined: counters stick at all-ones on overflow, and ovf_o is set.
- Undefined: counters wrap to 0 on overflow, and ovf_o is still set.

## Structure
- Shared package `perf_pkg`: FSM state enum (ST_IDLE, ST_DUMP), channel constant CH_CYCLE=0, and the event bit positions EVT_STALL=0 and EVT_FLUSH=1.
- Sub-module `perf_counter`: one CNT_W channel with en, clr, sticky ovf, and wrap/saturate, instantiated NUM_CH times via generate. The top holds the shadows, FSM, halt compare, and read mux.

## Test plan
- Reset, then start_i=1 for 10 cycles with event_i=2'b01 on cycles 3 and 4 -> ch0=10, ch1=2, ch2=0.
- limit_i=30, start_i=1 -> halt_o high after the 30th counting edge, ch0 frozen at 30; clear_i -> all 0, halt_o=0, counting resumes.
- snap_i at ch0=7, ready toggling 1,0,1,1 -> beats idx 0,1,2 with data 7 and current events, stable during stall, rd_last_o on idx 2, busy_o falls after.
- clear_i and event_i[1] in the same cycle -> ch2=0. snap_i during DUMP -> ignored, no second dump.
- CNT_W=4, 17 enabled cycles -> with macro: ch0=15, ovf_o[0]=1. Without macro: ch0=1, ovf_o[0]=1.
- rst_i asserted mid-dump at idx 1 -> rd_valid_o=0, all counters 0 on the next cycle.
